// File: rtl/ad7606_emu.sv
// ---------------------------------------------------------------------------
// ad7606_emu
//   Responder model of the AD7606 parallel bus: the converter side that the
//   ad7606 controller talks to. A CONVST rising edge starts a counted
//   "conversion" (BUSY high), after which a snapshot of CHN_NUM pattern words
//   is taken and served one channel per RD falling edge while CS is low.
//   No analog behaviour; all timing is in clk cycles.
//
// Ports
//   clk            ad_clk domain clock
//   rst            synchronous reset, active high
//   ad_convstab    conversion start, rising edge triggers
//   ad_cs          chip select, active low
//   ad_rd          read strobe, active low, falling edge advances channel
//   ad_reset       device reset, active high, level sensitive
//   ad_os          oversampling code (7 behaves as 0)
//   pat_mode       data pattern select
//   ad_data        channel data
//   ad_data_oe     bus-drive enable (follows the registered chip select)
//   ad_busy        conversion in progress
//   ad_first_data  high while channel 0 is presented
//   sample_cnt     completed conversions, wrapping
//   ovr_err        sticky: CONVST edge seen while converting
// ---------------------------------------------------------------------------
module ad7606_emu #(
    parameter int CONV_CYCLES = 200,
    parameter int CHN_NUM     = 8,
    parameter int DATA_NBIT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ad_convstab,
    input  logic                 ad_cs,
    input  logic                 ad_rd,
    input  logic                 ad_reset,
    input  logic [2:0]           ad_os,
    input  logic [1:0]           pat_mode,
    output logic [DATA_NBIT-1:0] ad_data,
    output logic                 ad_data_oe,
    output logic                 ad_busy,
    output logic                 ad_first_data,
    output logic [15:0]          sample_cnt,
    output logic                 ovr_err
);

    localparam int PTR_W = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;
    // Room for CONV_CYCLES shifted by the largest oversampling code (6).
    localparam int TMR_W = $clog2(CONV_CYCLES + 1) + 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Pattern word for channel n of sample s.
    function automatic logic [DATA_NBIT-1:0] pattern_word(
        input logic [1:0]  mode,
        input logic [15:0] s,
        input logic [2:0]  n
    );
        logic [15:0] w;
        case (mode)
            2'd0:    w = {n, s[12:0]};
            2'd1:    w = 16'hA000 | {13'd0, n};
            2'd2:    w = s[0] ? 16'hAAAA : 16'h5555;
            2'd3:    w = 16'h0000;
            default: w = 16'h0000;
        endcase
        return DATA_NBIT'(w);
    endfunction

    // Input stage registers
    logic                 convst_q_r;
    logic                 convst_qq_r;
    logic                 cs_q_r;
    logic                 rd_q_r;
    logic                 rd_qq_r;
    logic                 reset_q_r;
    logic [2:0]           os_q_r;
    logic                 oe_r;

    // Core state
    state_t               state_r;
    state_t               state_nxt_s;
    logic [TMR_W-1:0]     timer_r;
    logic                 busy_r;
    logic                 ovr_r;
    logic [15:0]          sample_cnt_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [DATA_NBIT-1:0] data_r;
    logic                 first_r;
    logic [DATA_NBIT-1:0] snap_r [CHN_NUM];

    logic                 conv_rise_s;
    logic                 rd_fall_s;
    logic                 hard_rst_s;
    logic [2:0]           os_eff_s;
    logic [TMR_W-1:0]     load_val_s;
    logic                 tmr_load_s;
    logic                 ovr_set_s;

    assign conv_rise_s = convst_q_r & ~convst_qq_r;
    assign rd_fall_s   = ~rd_q_r & rd_qq_r & ~cs_q_r;
    assign hard_rst_s  = rst | reset_q_r;
    assign os_eff_s    = (os_q_r == 3'd7) ? 3'd0 : os_q_r;
    assign load_val_s  = TMR_W'(CONV_CYCLES) << os_eff_s;

    // Single register stage on the bus pins plus the delayed copies for edges.
    // The drive enable is registered in the same stage so it equals ~cs_q,
    // and is held off while the device reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            convst_q_r  <= 1'b0;
            convst_qq_r <= 1'b0;
            cs_q_r      <= 1'b1;
            rd_q_r      <= 1'b1;
            rd_qq_r     <= 1'b1;
            reset_q_r   <= 1'b0;
            os_q_r      <= 3'd0;
            oe_r        <= 1'b0;
        end else begin
            convst_q_r  <= ad_convstab;
            convst_qq_r <= convst_q_r;
            cs_q_r      <= ad_cs;
            rd_q_r      <= ad_rd;
            rd_qq_r     <= rd_q_r;
            reset_q_r   <= ad_reset;
            os_q_r      <= ad_os;
            oe_r        <= ~ad_cs & ~ad_reset;
        end
    end

    // Next-state logic: conversion sequencing, timer load and overrun detect.
    always_comb begin
        state_nxt_s = state_r;
        tmr_load_s  = 1'b0;
        ovr_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (conv_rise_s) begin
                    state_nxt_s = ST_CONV;
                    tmr_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                // <= 1 rather than == 1 so a corrupted zero timer cannot hang us.
                if (timer_r <= TMR_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
                if (conv_rise_s) begin
                    ovr_set_s = 1'b1;
                end else begin
                    ovr_set_s = 1'b0;
                end
            end
            ST_DONE: begin
                // Back-to-back start is legal right at the end of a conversion.
                if (conv_rise_s) begin
                    state_nxt_s = ST_CONV;
                    tmr_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, timer, snapshot and readout registers.
    always_ff @(posedge clk) begin
        if (hard_rst_s) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TMR_W{1'b0}};
            busy_r       <= 1'b0;
            ovr_r        <= 1'b0;
            sample_cnt_r <= 16'd0;
            ptr_r        <= {PTR_W{1'b0}};
            data_r       <= {DATA_NBIT{1'b0}};
            first_r      <= 1'b0;
            for (int i = 0; i < CHN_NUM; i++) begin
                snap_r[i] <= {DATA_NBIT{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_CONV);

            if (tmr_load_s) begin
                timer_r <= load_val_s;
            end else if (state_r == ST_CONV) begin
                timer_r <= timer_r - TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end

            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end

            // DONE takes priority: a read landing in the same cycle is dropped.
            if (state_r == ST_DONE) begin
                for (int i = 0; i < CHN_NUM; i++) begin
                    snap_r[i] <= pattern_word(pat_mode, sample_cnt_r, 3'(i));
                end
                sample_cnt_r <= sample_cnt_r + 16'd1;
                ptr_r        <= {PTR_W{1'b0}};
                data_r       <= pattern_word(pat_mode, sample_cnt_r, 3'd0);
                first_r      <= 1'b1;
            end else if (rd_fall_s) begin
                data_r  <= snap_r[ptr_r];
                first_r <= (ptr_r == {PTR_W{1'b0}});
                if (ptr_r == PTR_W'(CHN_NUM - 1)) begin
                    ptr_r <= {PTR_W{1'b0}};
                end else begin
                    ptr_r <= ptr_r + PTR_W'(1);
                end
            end
        end
    end

    assign ad_data       = data_r;
    assign ad_data_oe    = oe_r;
    assign ad_busy       = busy_r;
    assign ad_first_data = first_r;
    assign sample_cnt    = sample_cnt_r;
    assign ovr_err       = ovr_r;

endmodule

// File: tb/tb_ad7606_emu.sv
// ---------------------------------------------------------------------------
// tb_ad7606_emu
//   Drives conversions and CS/RD reads into ad7606_emu and compares every
//   observable output against a transaction-level model: busy width from the
//   oversampling rule, snapshot contents from the pattern arithmetic, and a
//   channel pointer that cycles through the snapshot.
// ---------------------------------------------------------------------------
module tb_ad7606_emu;

    localparam int CONV = 10;
    localparam int CHN  = 8;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ad_convstab;
    logic          ad_cs;
    logic          ad_rd;
    logic          ad_reset;
    logic [2:0]    ad_os;
    logic [1:0]    pat_mode;
    logic [DW-1:0] ad_data;
    logic          ad_data_oe;
    logic          ad_busy;
    logic          ad_first_data;
    logic [15:0]   sample_cnt;
    logic          ovr_err;

    ad7606_emu #(
        .CONV_CYCLES (CONV),
        .CHN_NUM     (CHN),
        .DATA_NBIT   (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ad_convstab   (ad_convstab),
        .ad_cs         (ad_cs),
        .ad_rd         (ad_rd),
        .ad_reset      (ad_reset),
        .ad_os         (ad_os),
        .pat_mode      (pat_mode),
        .ad_data       (ad_data),
        .ad_data_oe    (ad_data_oe),
        .ad_busy       (ad_busy),
        .ad_first_data (ad_first_data),
        .sample_cnt    (sample_cnt),
        .ovr_err       (ovr_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [15:0] m_cnt;
    logic [15:0] m_snap [CHN];
    int          m_ptr;
    logic [15:0] m_data;
    logic        m_first;
    logic        m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Channel value straight from the pattern definitions, integer arithmetic.
    function automatic logic [15:0] ref_word(input int mode, input int s, input int n);
        case (mode)
            0:       return 16'((n * 8192 + (s % 8192)) % 65536);
            1:       return 16'(40960 + n);
            2:       return ((s % 2) == 1) ? 16'hAAAA : 16'h5555;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 16'd0;
        for (int i = 0; i < CHN; i++) m_snap[i] = 16'd0;
        m_ptr   = 0;
        m_data  = 16'd0;
        m_first = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_data"},  32'(ad_data),       32'(m_data));
        check({tag, "_first"}, 32'(ad_first_data), 32'(m_first));
        check({tag, "_cnt"},   32'(sample_cnt),    32'(m_cnt));
        check({tag, "_ovr"},   32'(ovr_err),       32'(m_ovr));
    endtask

    task automatic do_rst();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_busy", 32'(ad_busy), 32'd0);
        check("rst_oe", 32'(ad_data_oe), 32'd0);
        check_outs("rst");
    endtask

    // One CONVST pulse; optionally a second edge while busy.
    task automatic do_conv(input int os, input int pat, input bit extra);
        int lat;
        int width;
        bit seen;
        bit ended;
        int exp_w;
        lat = 0; width = 0; seen = 1'b0; ended = 1'b0;
        exp_w = CONV * (2 ** ((os == 7) ? 0 : os));
        ad_os    = 3'(os);
        pat_mode = 2'(pat);
        @(negedge clk) ad_convstab = 1'b1;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (i == 1) ad_convstab = 1'b0;
            if (extra && i == 4) ad_convstab = 1'b1;
            if (extra && i == 5) ad_convstab = 1'b0;
            if (ad_busy) begin
                if (!seen) lat = i;
                seen = 1'b1;
                width++;
            end else if (seen) begin
                ended = 1'b1;
                break;
            end
        end
        check("busy_end", 32'(ended), 32'd1);
        check("busy_lat", 32'(lat), 32'd2);
        check("busy_width", 32'(width), 32'(exp_w));
        for (int n = 0; n < CHN; n++) m_snap[n] = ref_word(pat, int'(m_cnt), n);
        m_cnt   = m_cnt + 16'd1;
        m_ptr   = 0;
        m_data  = m_snap[0];
        m_first = 1'b1;
        if (extra) m_ovr = 1'b1;
        @(negedge clk);
        check_outs("conv");
    endtask

    // One RD strobe, with CS asserted or not.
    task automatic do_read(input bit with_cs);
        @(negedge clk);
        if (with_cs) ad_cs = 1'b0;
        ad_rd = 1'b0;
        @(negedge clk) ad_rd = 1'b1;
        check("rd_oe", 32'(ad_data_oe), 32'(with_cs));
        check("rd_early", 32'(ad_data), 32'(m_data));
        if (with_cs) begin
            m_data  = m_snap[m_ptr];
            m_first = (m_ptr == 0);
            m_ptr   = (m_ptr + 1) % CHN;
        end
        @(negedge clk);
        check_outs("rd");
        ad_cs = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ad_convstab = 1'b0; ad_cs = 1'b1; ad_rd = 1'b1;
        ad_reset = 1'b0; ad_os = 3'd0; pat_mode = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_busy", 32'(ad_busy), 32'd0);
        check("init_oe", 32'(ad_data_oe), 32'd0);
        check_outs("init");

        // Basic conversion and a full wrap of the channel pointer
        do_conv(0, 1, 1'b0);
        for (int r = 0; r < 9; r++) do_read(1'b1);

        // Oversampling: code 3 stretches, code 7 behaves as 0
        do_conv(3, 1, 1'b0);
        do_conv(7, 1, 1'b0);

        // Pattern 0 advancing with sample count, then pattern 2 alternation
        do_rst();
        for (int c = 0; c < 3; c++) begin
            do_conv(0, 0, 1'b0);
            for (int r = 0; r < 6; r++) do_read(1'b1);
        end
        for (int c = 0; c < 2; c++) begin
            do_conv(0, 2, 1'b0);
            do_read(1'b1);
        end

        // Overrun: busy width unaffected, flag sticky across conversions
        do_conv(0, 2, 1'b1);
        do_conv(0, 1, 1'b0);
        for (int r = 0; r < 3; r++) do_read(1'b1);
        do_rst();
        do_read(1'b1);
        do_conv(0, 1, 1'b0);
        for (int r = 0; r < 2; r++) do_read(1'b1);

        // Device reset in the middle of a conversion
        do_conv(0, 1, 1'b1);
        ad_os = 3'd0; pat_mode = 2'd1;
        @(negedge clk) ad_convstab = 1'b1;
        @(negedge clk) ad_convstab = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_areset_busy", 32'(ad_busy), 32'd1);
        ad_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("areset_busy", 32'(ad_busy), 32'd0);
        ad_reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outs("areset");
        do_conv(0, 1, 1'b0);
        do_read(1'b1);

        // Read strobe without chip select is ignored
        do_read(1'b0);

        // Sample counter wrap
        force dut.sample_cnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.sample_cnt_r;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        check("wrap_pre", 32'(sample_cnt), 32'h0000FFFF);
        do_conv(0, 0, 1'b0);
        for (int r = 0; r < 3; r++) do_read(1'b1);

        // Randomised conversions and reads
        for (int k = 0; k < 10; k++) begin
            int os_r;
            int pat_r;
            int nrd;
            os_r  = int'($urandom_range(7, 0));
            pat_r = int'($urandom_range(3, 0));
            nrd   = int'($urandom_range(10, 0));
            do_conv(os_r, pat_r, 1'($urandom_range(1, 0)));
            for (int r = 0; r < nrd; r++) do_read(1'($urandom_range(3, 0) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ad7606_emu.md
Name: ad7606_emu

Overview:
- Synthesizable responder model of the AD7606 parallel interface, i.e. the converter end of the bus driven by the ad7606 controller.
- It answers CONVST/CS/RD with BUSY, FIRST_DATA and 16-bit channel data taken from an internal pattern generator.
- It is placed in the ad_clk domain for board-less loopback tests of the acquisition → ad_cache → USB path, and as a bench model.
- It has no analog behaviour. Timing is counted in clk cycles.

Parameters:
- CONV_CYCLES, 200, base conversion time in clk cycles at OS=0 (4 us at 50 MHz); must be ≥2.
- CHN_NUM, 8, channels returned per conversion.
- DATA_NBIT, 16, sample width.

Ports:
- clk  in  1  ad_clk, 50 MHz
- rst  in  1  synchronous reset, active high
- ad_convstab  in  1  conversion start; rising edge starts a conversion
- ad_cs  in  1  chip select, active low
- ad_rd  in  1  read strobe, active low; falling edge advances the channel
- ad_reset  in  1  device reset, active high, level sensitive
- ad_os  in  3  oversampling ratio code
- pat_mode  in  2  data pattern select
- ad_data  out  DATA_NBIT  channel data
- ad_data_oe  out  1  bus-drive enable (= ~cs_q)
- ad_busy  out  1  conversion in progress
- ad_first_data  out  1  high while channel 0 is on ad_data
- sample_cnt  out  16  completed conversions, wraps
- ovr_err  out  1  sticky: CONVST edge received while busy

Behaviour:
- Input sampling: ad_convstab, ad_cs, ad_rd and ad_reset are registered once (_q), and the previous value is kept (_qq).
  - Edges: conv_rise = convst_q & ~convst_qq; rd_fall = ~rd_q & rd_qq & ~cs_q.
  - Clk is treated as the master. No metastability handling beyond the one register.
- rst or ad_reset_q forces the full reset state: all outputs 0, ovr_err 0, sample_cnt 0, snapshot registers 0, channel pointer 0, FSM to IDLE. An in-flight conversion is aborted, and no snapshot update or sample_cnt increment happens.
- FSM states:
  - IDLE:
    - conv_rise → CONV; ad_busy=1 from the next cycle.
    - Load the timer with CONV_CYCLES<<os_eff, where os_eff = ad_os_q for codes 0..6 and 0 for code 7. ad_os is latched at the edge.
  - CONV:
    - The timer decrements each cycle; ad_busy stays high for exactly CONV_CYCLES<<os_eff cycles.
    - At timer==1 → DONE.
    - conv_rise in CONV is ignored and sets ovr_err.
  - DONE (1 cycle):
    - ad_busy=0.
    - Snapshot all CHN_NUM channels from the pattern using the current sample_cnt, then sample_cnt+1 (wraps at 0xFFFF→0).
    - Channel pointer to 0. ad_data updated to channel 0 and ad_first_data=1.
    - → IDLE.
    - A conv_rise in DONE is accepted: transition direct to CONV.
- Pattern for channel n (n=0..7, s = sample_cnt before increment), all arithmetic mod 2^16:
  - 0: {n[2:0], s[12:0]}
  - 1: 16'hA000 | n
  - 2: s[0] ? 16'hAAAA : 16'h5555
  - 3: 16'h0000
- Readout:
  - Each rd_fall: ad_data <= snapshot[ptr], ad_first_data <= (ptr==0), ptr <= ptr+1. Wrap is CHN_NUM-1→0, so a 9th read returns channel 0 again with first_data=1.
  - Output latency: ad_data valid 2 cycles after the ad_rd falling edge at the pin.
  - ad_data holds between reads.
  - Reads during CONV are permitted and return the previous snapshot. Reads while cs_q=1 are ignored.
  - DONE and rd_fall in the same cycle: DONE wins, ptr=0, and the read is discarded.

Test Plan:
- Reset, then CONV_CYCLES=10, os=0, pat 1: one convst pulse → busy high exactly 10 cycles starting 2 cycles after the pin edge; sample_cnt=1. Eight CS/RD reads → A000..A007; first_data only on the first; 9th read → A000 with first_data=1.
- os=3, then os=7: busy width 80 cycles, then 10 cycles.
- pat 0, three conversions, read ch 5 each time → 0xA000, 0xA001, 0xA002; pat 2 alternates 5555/AAAA.
- Second convst edge mid-busy → busy width unchanged, sample_cnt +1 only, ovr_err=1 until rst.
- ad_reset pulse mid-conversion → busy drops within 2 cycles, sample_cnt=0, data=0; next convst works normally. rst mid-readout → ptr restarts at 0.
- Force sample_cnt to 0xFFFF, convert → 0x0000; rd during cs=1 → ad_data unchanged, ad_data_oe=0.
